// File: rtl/debounce_filter.sv
// Debounce filter: two-flop synchronizer feeding a four-state acceptance FSM.
// A new level is accepted after STABLE consecutive synchronized samples while en=1.
module debounce_filter #(
  parameter int unsigned STABLE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  input  logic en,
  output logic q,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int unsigned    CW       = $clog2(STABLE + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    LOW      = 2'd0,
    CHK_HIGH = 2'd1,
    HIGH     = 2'd2,
    CHK_LOW  = 2'd3
  } state_t;

  logic          r_s1;
  logic          r_d_s;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_rise;
  logic          r_fall;

  state_t        w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_rise_nxt;
  logic          w_fall_nxt;

  // Synchronizer runs every cycle, independent of en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1  <= 1'b0;
      r_d_s <= 1'b0;
    end else begin
      r_s1  <= d;
      r_d_s <= r_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= LOW;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  // Entering a CHK state counts the triggering sample as the first one.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    case (r_state)
      LOW: begin
        if (en && r_d_s) begin
          if (STABLE == 1) begin
            w_state_nxt = HIGH;
            w_cnt_nxt   = '0;
            w_rise_nxt  = 1'b1;
          end else begin
            w_state_nxt = CHK_HIGH;
            w_cnt_nxt   = CW'(1);
          end
        end
      end
      CHK_HIGH: begin
        if (!en || !r_d_s) begin
          w_state_nxt = LOW;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = HIGH;
          w_cnt_nxt   = '0;
          w_rise_nxt  = 1'b1;
        end else if (r_cnt != CNT_MAX) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      HIGH: begin
        if (en && !r_d_s) begin
          if (STABLE == 1) begin
            w_state_nxt = LOW;
            w_cnt_nxt   = '0;
            w_fall_nxt  = 1'b1;
          end else begin
            w_state_nxt = CHK_LOW;
            w_cnt_nxt   = CW'(1);
          end
        end
      end
      CHK_LOW: begin
        if (!en || r_d_s) begin
          w_state_nxt = HIGH;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = LOW;
          w_cnt_nxt   = '0;
          w_fall_nxt  = 1'b1;
        end else if (r_cnt != CNT_MAX) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = LOW;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign q    = (r_state == HIGH) || (r_state == CHK_LOW);
  assign busy = (r_state == CHK_HIGH) || (r_state == CHK_LOW);
  assign rise = r_rise;
  assign fall = r_fall;

endmodule

// File: tb/tb_debounce_filter.sv
// Directed bench for debounce_filter (STABLE=4 and STABLE=1 instances).
// Expected pulses are queued as {rise, fall, cycle}; monitors pop them when a pulse appears.
module tb_debounce_filter;

  localparam int W = 34;

  logic clk = 1'b0;
  logic rst_n;
  logic d;
  logic en;
  logic d1;
  logic q, rise, fall, busy;
  logic q1, rise1, fall1, busy1;

  int unsigned cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp1_q[$];

  debounce_filter #(.STABLE(4)) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (d),
    .en   (en),
    .q    (q),
    .rise (rise),
    .fall (fall),
    .busy (busy)
  );

  debounce_filter #(.STABLE(1)) u_dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (d1),
    .en   (en),
    .q    (q1),
    .rise (rise1),
    .fall (fall1),
    .busy (busy1)
  );

  // Clock / cycle counter: cyc equals the number of rising edges seen so far.
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_word(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got rise=%0b fall=%0b cycle=%0d expected rise=%0b fall=%0b cycle=%0d",
               name, act[W-1], act[W-2], act[31:0], exp[W-1], exp[W-2], exp[31:0]);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitors: every pulse must match the head of its expected queue.
  always @(negedge clk) begin
    if (rise || fall) begin
      if (exp_q.size() == 0) begin
        check_word("dut_unexpected_pulse", {rise, fall, cyc}, '0);
      end else begin
        check_word("dut_pulse", {rise, fall, cyc}, exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rise1 || fall1) begin
      if (exp1_q.size() == 0) begin
        check_word("dut1_unexpected_pulse", {rise1, fall1, cyc}, '0);
      end else begin
        check_word("dut1_pulse", {rise1, fall1, cyc}, exp1_q.pop_front());
      end
    end
  end

  // After a level change (or reset release) at cycle E, the STABLE=4 FSM is busy
  // after edges E+3..E+5 and accepts at E+6.
  task automatic watch_accept(input logic v, input int nk);
    for (int k = 1; k <= nk; k++) begin
      @(negedge clk);
      check_bit("acc_busy", busy, (k >= 3 && k <= 5));
      check_bit("acc_q", q, v ? (k >= 6) : (k < 6));
      check_bit("acc_rise", rise, v && (k == 6));
      check_bit("acc_fall", fall, !v && (k == 6));
    end
  endtask

  task automatic drive_edge(input logic v);
    logic [31:0] t;
    d = v;
    t = cyc + 6;
    exp_q.push_back({v, ~v, t});
    watch_accept(v, 8);
  endtask

  initial begin
    logic [31:0] t;
    rst_n = 1'b1;
    d     = 1'b1;
    en    = 1'b1;
    d1    = 1'b0;

    // Reset asserted with d=1: outputs clear immediately and stay clear.
    #2 rst_n = 1'b0;
    #1;
    check_bit("rst_q", q, 1'b0);
    check_bit("rst_rise", rise, 1'b0);
    check_bit("rst_fall", fall, 1'b0);
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_q1", q1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check_bit("rst_hold_q", q, 1'b0);
    check_bit("rst_hold_busy", busy, 1'b0);

    // Release with d held high: rise at the 6th edge.
    rst_n = 1'b1;
    t = cyc + 6;
    exp_q.push_back({1'b1, 1'b0, t});
    watch_accept(1'b1, 8);

    // en=0 in HIGH with sub-cycle glitching on d: everything frozen.
    en = 1'b0;
    fork
      begin
        repeat (54) #3 d = ~d;
      end
      begin
        for (int k = 1; k <= 8; k++) begin
          @(negedge clk);
          check_bit("frz_q", q, 1'b1);
          check_bit("frz_busy", busy, 1'b0);
          check_bit("frz_rise", rise, 1'b0);
          check_bit("frz_fall", fall, 1'b0);
        end
      end
    join
    d = 1'b1;
    repeat (3) @(negedge clk);
    en = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check_bit("frz_after_q", q, 1'b1);
      check_bit("frz_after_busy", busy, 1'b0);
    end

    // From HIGH, d low steady: single fall pulse at the 6th edge.
    drive_edge(1'b0);

    // Pulse of 3 synchronized samples: counted but rejected.
    d = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check_bit("glitch_busy", busy, (k >= 3 && k <= 5));
      check_bit("glitch_q", q, 1'b0);
      if (k == 3) d = 1'b0;
    end

    // en dropped mid-count: abort back to LOW without a pulse.
    d = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check_bit("abort_busy", busy, (k == 3 || k == 4));
      check_bit("abort_q", q, 1'b0);
      if (k == 4) en = 1'b0;
    end
    d = 1'b0;
    repeat (3) @(negedge clk);
    en = 1'b1;

    // Reset pulse between edges at cnt=2: count discarded, restart after release.
    d = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check_bit("pre_rst_busy", busy, (k >= 3));
    end
    #3 rst_n = 1'b0;
    #1;
    check_bit("mid_rst_q", q, 1'b0);
    check_bit("mid_rst_busy", busy, 1'b0);
    check_bit("mid_rst_rise", rise, 1'b0);
    check_bit("mid_rst_fall", fall, 1'b0);
    #2 rst_n = 1'b1;
    t = cyc + 6;
    exp_q.push_back({1'b1, 1'b0, t});
    watch_accept(1'b1, 8);

    // STABLE=1: accept at the 3rd edge, never busy.
    d1 = 1'b1;
    t = cyc + 3;
    exp1_q.push_back({1'b1, 1'b0, t});
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check_bit("s1_q_rise", q1, (k >= 3));
      check_bit("s1_rise", rise1, (k == 3));
      check_bit("s1_busy", busy1, 1'b0);
    end
    d1 = 1'b0;
    t = cyc + 3;
    exp1_q.push_back({1'b0, 1'b1, t});
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check_bit("s1_q_fall", q1, (k < 3));
      check_bit("s1_fall", fall1, (k == 3));
      check_bit("s1_busy_f", busy1, 1'b0);
    end

    repeat (3) @(negedge clk);
    check_int("exp_q_drained", exp_q.size(), 0);
    check_int("exp1_q_drained", exp1_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
